// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: transforms COLS_PER_CYCLE columns per clock between
// valid/ready handshakes; a bypass flag passes the state through for the final round.
module inv_mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
  localparam logic [2:0] NCOL     = 3'(COLS_PER_CYCLE);

  state_t       state_r, state_s;
  logic [127:0] data_r, data_s;
  logic [127:0] result_r, result_s;
  logic [1:0]   col_cnt_r, col_cnt_s;
  logic         accept_s;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 9, b, d and e are built from the x2/x4/x8 doubling chain.
  function automatic logic [31:0] inv_col(input logic [31:0] a);
    logic [7:0] x1 [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int k = 0; k < 4; k++) begin
      x1[k] = a[31-8*k -: 8];
      x2[k] = xtime(x1[k]);
      x4[k] = xtime(x2[k]);
      x8[k] = xtime(x4[k]);
      m9[k] = x8[k] ^ x1[k];
      mb[k] = x8[k] ^ x2[k] ^ x1[k];
      md[k] = x8[k] ^ x4[k] ^ x1[k];
      me[k] = x8[k] ^ x4[k] ^ x2[k];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  assign in_ready  = (state_r == IDLE) || ((state_r == DONE) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r == BUSY);
  assign out_data  = result_r;

  // Next-state, column-write and accept logic.
  always_comb begin : next_logic
    logic [1:0] off;
    off       = 2'd0;
    state_s   = state_r;
    data_s    = data_r;
    result_s  = result_r;
    col_cnt_s = col_cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = in_bypass ? DONE : BUSY;
        else          state_s = IDLE;
      end
      BUSY: begin
        // Columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 are the ones at offset < NCOL.
        for (int c = 0; c < 4; c++) begin
          off = 2'(c) - col_cnt_r;
          if ({1'b0, off} < NCOL) result_s[127-32*c -: 32] = inv_col(data_r[127-32*c -: 32]);
          else                    result_s[127-32*c -: 32] = result_r[127-32*c -: 32];
        end
        col_cnt_s = col_cnt_r + STEP;
        if (col_cnt_r == LAST_COL) state_s = DONE;
        else                       state_s = BUSY;
      end
      DONE: begin
        if (accept_s)       state_s = in_bypass ? DONE : BUSY;
        else if (out_ready) state_s = IDLE;
        else                state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
    // Accepts only occur in IDLE/DONE, so no column write is overridden here.
    if (accept_s) begin
      data_s    = in_data;
      col_cnt_s = 2'd0;
      if (in_bypass) result_s = in_data;
      else           result_s = result_r;
    end else begin
      data_s = data_r;
    end
  end

  // State, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      data_r    <= 128'd0;
      result_r  <= 128'd0;
      col_cnt_r <= 2'd0;
    end else begin
      state_r   <= state_s;
      data_r    <= data_s;
      result_r  <= result_s;
      col_cnt_r <= col_cnt_s;
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Scoreboard bench for inv_mix_columns_iter: a driver pushes expected states, a monitor
// pops and compares on every output handshake; two extra instances cover COLS=2 and 4.
module tb_inv_mix_columns_iter;

  logic         clk = 1'b0, rst_n = 1'b1;
  logic         in_valid = 1'b0, in_bypass = 1'b0, out_ready = 1'b1;
  logic         x_valid = 1'b0, one = 1'b1;
  logic [127:0] in_data = 128'd0;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_data;
  logic         in_ready2, out_valid2, busy2, in_ready4, out_valid4, busy4;
  logic [127:0] out_data2, out_data4;

  int n_vec = 0, n_err = 0;
  int cyc = 0, last_acc = 0, last_hs = 0;

  typedef struct { logic [127:0] d; int acc; int lat; } item_t;
  item_t q[$];

  localparam logic [127:0] V2_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V3_IN  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] V3_OUT = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] V4     = 128'h01234567_89abcdef_fedcba98_76543210;

  inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_bypass(in_bypass), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy));

  inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_bypass(in_bypass), .out_valid(out_valid2), .out_ready(one), .out_data(out_data2),
    .busy(busy2));

  inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(in_ready4), .in_data(in_data),
    .in_bypass(in_bypass), .out_valid(out_valid4), .out_ready(one), .out_data(out_data4),
    .busy(busy4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // Reference: circulant matrix rows {0e,0b,0d,09} rotated right by the row index.
  function automatic logic [127:0] model(input logic [127:0] s);
    logic [7:0]   base [4];
    logic [127:0] r;
    logic [7:0]   acc;
    base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    r = 128'd0;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(s[127-32*c-8*k -: 8], base[(k - rr + 4) % 4]);
        r[127-32*c-8*rr -: 8] = acc;
      end
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [127:0] d, input logic byp, input logic [127:0] exp, input int lat);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_bypass = byp;
    #3;
    while (!in_ready && n < 100) begin
      @(negedge clk); #3; n++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end else begin
      q.push_back('{exp, cyc + 1, lat});
      last_acc = cyc + 1;
    end
    @(negedge clk);
    in_valid = 1'b0; in_bypass = 1'b0;
  endtask

  task automatic fast_check(input logic [127:0] d, input logic [127:0] exp);
    int  a;
    logic s2, s4;
    s2 = 1'b0; s4 = 1'b0;
    x_valid = 1'b1; in_data = d; in_bypass = 1'b0;
    @(posedge clk); @(negedge clk);
    x_valid = 1'b0; a = cyc;
    for (int k = 0; k < 8; k++) begin
      #4;
      if (out_valid2 && !s2) begin
        s2 = 1'b1;
        chk("lat_cols2", 128'(cyc - a), 128'(2));
        chk("data_cols2", out_data2, exp);
      end
      if (out_valid4 && !s4) begin
        s4 = 1'b1;
        chk("lat_cols4", 128'(cyc - a), 128'(1));
        chk("data_cols4", out_data4, exp);
      end
      @(negedge clk);
    end
    chk("seen_cols2", 128'(s2), 128'(1));
    chk("seen_cols4", 128'(s4), 128'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    chk("drain", 128'(q.size()), 128'(0));
  endtask

  // Monitor: latency on each fresh out_valid, data on each output handshake.
  initial begin : monitor
    logic prev_v, prev_hs;
    prev_v = 1'b0; prev_hs = 1'b0;
    forever begin
      @(negedge clk); #4;
      if (!rst_n) begin
        prev_v = 1'b0; prev_hs = 1'b0;
      end else begin
        if (out_valid && !(prev_v && !prev_hs)) begin
          if (q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL spurious_valid: out_valid=1 with nothing outstanding, data %h", out_data);
          end else begin
            chk("latency", 128'(cyc - q[0].acc), 128'(q[0].lat));
          end
        end
        if (out_valid && out_ready) begin
          last_hs = cyc + 1;
          if (q.size() != 0) begin
            chk("out_data", out_data, q[0].d);
            void'(q.pop_front());
          end
        end
        prev_v  = out_valid;
        prev_hs = out_valid && out_ready;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [127:0] d;
    logic         stable_bad, rdy_bad;
    int           prev, n;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_data", out_data, 128'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    send(V2_IN, 1'b0, V2_OUT, 4);
    send(V3_IN, 1'b0, V3_OUT, 4);
    // Bypass copies on the accepting edge: out_valid seen the very next cycle.
    send(V4, 1'b1, V4, 0);
    drain();

    fast_check(V3_IN, V3_OUT);
    fast_check(V2_IN, V2_OUT);

    // Reset in the middle of a transform.
    send(V2_IN, 1'b0, V2_OUT, 4);
    @(negedge clk);
    chk("busy_mid", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_out_data", out_data, 128'd0);
    q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Backpressure, then release with the next state ready.
    out_ready = 1'b0;
    send(V3_IN, 1'b0, V3_OUT, 4);
    n = 0;
    do begin
      @(negedge clk); #4; n++;
    end while (!out_valid && n < 50);
    stable_bad = 1'b0; rdy_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #4;
      if (out_data !== V3_OUT) stable_bad = 1'b1;
      if (in_ready !== 1'b0) rdy_bad = 1'b1;
    end
    chk("stall_stable", 128'(stable_bad), 128'(0));
    chk("stall_in_ready_low", 128'(rdy_bad), 128'(0));
    @(negedge clk);
    out_ready = 1'b1;
    send(V2_IN, 1'b0, V2_OUT, 4);
    chk("same_cycle_handshake", 128'(last_acc), 128'(last_hs));

    // Back-to-back random states: one accept every L+1 = 5 edges.
    prev = last_acc;
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, 1'b0, model(d), 4);
      chk("throughput", 128'(last_acc - prev), 128'(5));
      prev = last_acc;
    end
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 1'b1, d, 0);
    send(~d, 1'b1, ~d, 0);
    chk("bypass_b2b", 128'(last_acc - prev), 128'(6));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
